// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: stall/flush FSM states and the RV32 major opcodes
// used by the hazard unit and decoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic is_mem_opcode(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled data-memory cycles; forces release with a one-cycle bus error once the
// access has waited MEM_TIMEOUT-1 cycles.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pend,
  output logic o_stall,
  output logic o_bus_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_timeout;

  assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign o_stall   = i_pend & ~w_timeout;
  assign o_bus_err = i_pend & w_timeout;

  // Counts every stalled cycle of the access; any non-stall cycle ends it and clears.
  always_comb begin
    w_cnt_d = '0;
    if (o_stall) w_cnt_d = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_cnt <= '0;
    else          r_cnt <= w_cnt_d;
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges hazard-unit requests with
// the data-memory and divider wait FSMs into per-stage enable/bubble controls.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hz_lwstall,
  input  logic       i_hz_redirect,
  input  logic       i_mem_op_m,
  input  logic       i_dmem_ack,
  input  logic       i_div_op_e,
  input  logic       i_div_done,
  output logic       o_dmem_req,
  output logic       o_div_start,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_stallE,
  output logic       o_stallM,
  output logic       o_flushD,
  output logic       o_flushE,
  output logic       o_flushM,
  output logic       o_flushW,
  output logic       o_bus_err,
  output logic [1:0] o_state
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_d;

  logic w_in_div;
  logic w_mem_pend;
  logic w_mem_stall;
  logic w_bus_err;
  logic w_div_start;
  logic w_div_stall;
  logic w_stall_e;

  assign w_in_div = (r_state == DIV_WAIT);
  // While dividing, EX/MEM only carries bubbles, so MEM cannot hold a live access.
  assign w_mem_pend = i_reset & ~w_in_div & i_mem_op_m & ~i_dmem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mem_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_pend    (w_mem_pend),
    .o_stall   (w_mem_stall),
    .o_bus_err (w_bus_err)
  );

  assign w_div_start = ~w_in_div & i_div_op_e & ~w_mem_stall;
  assign w_div_stall = w_div_start | (w_in_div & ~i_div_done);
  assign w_stall_e   = w_mem_stall | w_div_stall;

  always_comb begin
    w_state_d = RUN;
    if (w_mem_stall)                   w_state_d = MEM_WAIT;
    else if (w_div_start)              w_state_d = DIV_WAIT;
    else if (w_in_div && !i_div_done)  w_state_d = DIV_WAIT;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= RUN;
    else          r_state <= w_state_d;
  end

  always_comb begin
    o_dmem_req  = 1'b0;
    o_div_start = 1'b0;
    o_stallF    = 1'b0;
    o_stallD    = 1'b0;
    o_stallE    = 1'b0;
    o_stallM    = 1'b0;
    o_flushD    = 1'b0;
    o_flushE    = 1'b0;
    o_flushM    = 1'b0;
    o_flushW    = 1'b0;
    o_bus_err   = 1'b0;
    if (i_reset) begin
      o_bus_err = w_bus_err;
      if (w_mem_stall) begin
        o_dmem_req = 1'b1;
        o_stallF   = 1'b1;
        o_stallD   = 1'b1;
        o_stallE   = 1'b1;
        o_stallM   = 1'b1;
        o_flushW   = 1'b1;
      end else if (w_div_stall) begin
        o_div_start = w_div_start;
        o_stallF    = 1'b1;
        o_stallD    = 1'b1;
        o_stallE    = 1'b1;
        o_flushM    = 1'b1;
      end
      // A redirect held behind a stalled EX is re-presented once EX advances.
      if (!w_stall_e && i_hz_redirect) begin
        o_flushD = 1'b1;
        o_flushE = 1'b1;
      end else if (!w_stall_e && i_hz_lwstall) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end
    end
  end

  assign o_state = r_state;

endmodule
